txn_stream_arbiter: RTL and testbench
=====================================

TXN_STREAM_ARBITER -- requirements
Module: txn_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_STREAMS, default 5, meaning the number of requesting transaction streams (2..16).
REQ-002 SHALL have parameter HANDLE_W, default 4, meaning the handle width; the pool holds 2**HANDLE_W handles, numbered 0..2**HANDLE_W-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_STREAMS bits: per-stream request present.
REQ-006 SHALL have port req_end, input, NUM_STREAMS bits: per-stream operation, 1=end transaction, 0=begin transaction.
REQ-007 SHALL have port req_handle, input, NUM_STREAMS*HANDLE_W bits: the handle to end; used only when req_end=1.
REQ-008 SHALL have port req_has_parent, input, NUM_STREAMS bits: the begin request carries a source relation.
REQ-009 SHALL have port req_parent, input, NUM_STREAMS*HANDLE_W bits: the parent handle for the relation.
REQ-010 SHALL have port req_ready, output, NUM_STREAMS bits: one-hot grant, asserted for one cycle.
REQ-011 SHALL have port grant_handle, output, HANDLE_W bits: the handle allocated to a begin; valid while req_ready is asserted.
REQ-012 SHALL have port rec_valid, output, 1 bit, and port rec_ready, input, 1 bit: the record output handshake.
REQ-013 SHALL have the following record output ports:
- rec_kind, output, 1 bit: 0=BEGIN, 1=END.
- rec_stream, output, $clog2(NUM_STREAMS) bits.
- rec_handle, output, HANDLE_W bits.
- rec_parent, output, HANDLE_W bits.
- rec_has_parent, output, 1 bit.
REQ-014 SHALL have port live_count, output, HANDLE_W+1 bits: the number of allocated handles.
REQ-015 SHALL have ports pool_empty, output, 1 bit, and err, output, 1 bit: err is a one-cycle error pulse.

Function
REQ-016 SHALL hold one record register; arbitration SHALL occur in a cycle only when the register is empty or is drained in that cycle (rec_valid && rec_ready), which gives zero-bubble throughput of one record per cycle.
REQ-017 SHALL arbitrate round-robin among eligible streams, starting from the stream after the last granted one.
REQ-018 SHALL treat a stream as eligible when req_valid=1 and either req_end=1 or pool_empty=0; an ineligible begin SHALL be skipped, not blocked.
REQ-019 SHALL, on a begin grant:
- allocate the lowest-numbered free handle;
- drive grant_handle in that same cycle;
- increment live_count;
- load a BEGIN record on the next edge, so that rec_valid rises one cycle after req_ready.
REQ-020 SHALL, on an end grant of a live handle, free that handle, decrement live_count, and load an END record.
REQ-021 SHALL, on an end grant of a non-live handle, pulse err for one cycle, load no record, and leave the pool unchanged.
REQ-022 SHALL hold all rec_* fields stable while rec_valid=1 and rec_ready=0.
REQ-023 SHALL make a handle freed in cycle N allocatable in cycle N+1, not in cycle N.
REQ-024 SHALL assert pool_empty combinationally when live_count equals 2**HANDLE_W.
REQ-025 SHALL ignore req_parent whenever req_has_parent=0 and SHALL drive rec_parent to 0 in that case.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, clear these outputs and state:
- req_ready=0, rec_valid=0, err=0, live_count=0;
- all rec_* fields=0;
- all handles free;
- round-robin pointer at stream 0.
REQ-027 SHALL, when reset is asserted mid-operation, discard a pending record and free all handles without emitting END records.

Configuration
REQ-028 SHALL, with macro TXN_ARB_PARENT_CHECK_EN defined, handle a begin whose parent is not live as follows:
- pulse err;
- still allocate a handle;
- emit the BEGIN record with rec_has_parent=0.
REQ-029 SHALL, without TXN_ARB_PARENT_CHECK_EN, pass req_parent through unchecked.

Structure
REQ-030 SHALL take the following from shared package txn_arb_pkg:
- the rec_kind values (REC_BEGIN, REC_END);
- default parameter constants.
REQ-031 SHALL place the free bitmap, lowest-free encoder and live counter in sub-module txn_handle_pool.

Verification
REQ-032 Bench SHALL cover allocation order: streams 0 and 1 issue a begin in the same cycle -> stream 0 is granted handle 0 and stream 1 is granted handle 1 on the next arbitration, with live_count=2.
REQ-033 Bench SHALL cover fairness: all 5 streams request continuously with rec_ready=1 -> grants 0,1,2,3,4,0 on consecutive cycles.
REQ-034 Bench SHALL cover pool exhaustion: 16 begins, then a begin from stream 2 alongside an end of handle 5 from stream 3 -> only stream 3 is granted; stream 2 is granted handle 5 on a later cycle.
REQ-035 Bench SHALL cover back-pressure: rec_ready=0 for 4 cycles with a record pending -> the rec_* fields are stable and there is no req_ready.
REQ-036 Bench SHALL cover a bad end: an end of non-live handle 9 -> one err pulse, no record, and live_count unchanged.
REQ-037 Bench SHALL cover the parent check: with TXN_ARB_PARENT_CHECK_EN defined, a begin with parent 7 not live -> err pulse and rec_has_parent=0; without the macro -> rec_has_parent=1 and rec_parent=7.

Source files
------------

// File: rtl/txn_arb_pkg.sv
// txn_arb_pkg: record kinds and default parameters shared by the arbiter slice
package txn_arb_pkg;
  localparam int DEF_NUM_STREAMS = 5;
  localparam int DEF_HANDLE_W = 4;
  typedef enum logic {REC_BEGIN = 1'b0, REC_END = 1'b1} rec_kind_e;
endpackage

// File: rtl/txn_stream_arbiter_pool.sv
// txn_handle_pool: free bitmap, lowest-free encoder and live counter for the handle pool
module txn_handle_pool
  import txn_arb_pkg::*;
#(
  parameter int HANDLE_W = DEF_HANDLE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc_i,
  input  logic                     free_i,
  input  logic [HANDLE_W-1:0]      free_handle_i,
  output logic [HANDLE_W-1:0]      alloc_handle_o,
  output logic [2**HANDLE_W-1:0]   live_o,
  output logic [HANDLE_W:0]        live_count_o,
  output logic                     empty_o
);
  localparam int NH = 2**HANDLE_W;
  localparam logic [HANDLE_W:0] ONE = 1;
  logic [NH-1:0] free_q, free_d;
  logic [HANDLE_W:0] cnt_q, cnt_d;
  // Lowest-numbered free handle; reads only the registered bitmap so a handle freed this cycle waits a cycle
  always_comb begin
    alloc_handle_o = '0;
    for (int i = NH - 1; i >= 0; i--) if (free_q[i]) alloc_handle_o = HANDLE_W'(i);
  end
  // Next bitmap and count; alloc and free never coincide since one grant happens per cycle
  always_comb begin
    free_d = free_q;
    cnt_d = cnt_q;
    if (alloc_i) begin
      free_d[alloc_handle_o] = 1'b0;
      cnt_d = cnt_q + ONE;
    end
    if (free_i) begin
      free_d[free_handle_i] = 1'b1;
      cnt_d = cnt_q - ONE;
    end
  end
  // Pool state; reset frees every handle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      free_q <= '1;
      cnt_q <= '0;
    end else begin
      free_q <= free_d;
      cnt_q <= cnt_d;
    end
  end
  assign live_o = ~free_q;
  assign live_count_o = cnt_q;
  // The count never exceeds 2**HANDLE_W, so its MSB alone marks a full pool
  assign empty_o = cnt_q[HANDLE_W];
endmodule

// File: rtl/txn_stream_arbiter.sv
// txn_stream_arbiter: round-robin arbiter of begin/end transaction requests onto one record stream.
// Define TXN_ARB_PARENT_CHECK_EN to reject (err + drop relation) begin parents that are not live.
module txn_stream_arbiter
  import txn_arb_pkg::*;
#(
  parameter int NUM_STREAMS = DEF_NUM_STREAMS,
  parameter int HANDLE_W = DEF_HANDLE_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_STREAMS-1:0]          req_valid,
  input  logic [NUM_STREAMS-1:0]          req_end,
  input  logic [NUM_STREAMS*HANDLE_W-1:0] req_handle,
  input  logic [NUM_STREAMS-1:0]          req_has_parent,
  input  logic [NUM_STREAMS*HANDLE_W-1:0] req_parent,
  output logic [NUM_STREAMS-1:0]          req_ready,
  output logic [HANDLE_W-1:0]             grant_handle,
  output logic                            rec_valid,
  input  logic                            rec_ready,
  output logic                            rec_kind,
  output logic [$clog2(NUM_STREAMS)-1:0]  rec_stream,
  output logic [HANDLE_W-1:0]             rec_handle,
  output logic [HANDLE_W-1:0]             rec_parent,
  output logic                            rec_has_parent,
  output logic [HANDLE_W:0]               live_count,
  output logic                            pool_empty,
  output logic                            err
);
  localparam int SW = $clog2(NUM_STREAMS);
  logic [SW-1:0] ptr_q, gnt_idx, rec_stream_q;
  logic gnt_vld, take, is_end, end_ok, hp, par_bad, rec_hp_d, empty;
  logic rec_valid_q, rec_has_parent_q, err_q;
  rec_kind_e rec_kind_q;
  logic [NUM_STREAMS-1:0] elig;
  logic [HANDLE_W-1:0] end_h, par_h, alloc_h, rec_handle_q, rec_parent_q;
  logic [2**HANDLE_W-1:0] live;
  // Begins are skipped (not blocking) while the pool is empty
  assign elig = req_valid & (req_end | {NUM_STREAMS{~empty}});
  // Round-robin search for the first eligible stream at or after the pointer
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_STREAMS; k++)
      if (!gnt_vld && elig[(int'(ptr_q) + k) % NUM_STREAMS]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'((int'(ptr_q) + k) % NUM_STREAMS);
      end
  end
  assign take = rst_n & gnt_vld & (~rec_valid_q | rec_ready);
  assign is_end = req_end[gnt_idx];
  assign hp = req_has_parent[gnt_idx];
  assign end_h = req_handle[gnt_idx*HANDLE_W +: HANDLE_W];
  assign par_h = req_parent[gnt_idx*HANDLE_W +: HANDLE_W];
  assign end_ok = live[end_h];
`ifdef TXN_ARB_PARENT_CHECK_EN
  assign par_bad = hp & ~live[par_h];
`else
  assign par_bad = 1'b0;
`endif
  assign rec_hp_d = ~is_end & hp & ~par_bad;
  assign req_ready = {{(NUM_STREAMS-1){1'b0}}, take} << gnt_idx;
  assign grant_handle = alloc_h;
  txn_handle_pool #(.HANDLE_W(HANDLE_W)) u_pool (
    .clk(clk),
    .rst_n(rst_n),
    .alloc_i(take & ~is_end),
    .free_i(take & is_end & end_ok),
    .free_handle_i(end_h),
    .alloc_handle_o(alloc_h),
    .live_o(live),
    .live_count_o(live_count),
    .empty_o(empty)
  );
  // Pointer advance, error pulse and the single record register (held while stalled)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      err_q <= 1'b0;
      rec_valid_q <= 1'b0;
      rec_kind_q <= REC_BEGIN;
      rec_stream_q <= '0;
      rec_handle_q <= '0;
      rec_parent_q <= '0;
      rec_has_parent_q <= 1'b0;
    end else begin
      err_q <= take & (is_end ? ~end_ok : par_bad);
      if (take) ptr_q <= (gnt_idx == SW'(NUM_STREAMS - 1)) ? '0 : gnt_idx + 1'b1;
      if (take & (~is_end | end_ok)) begin
        rec_valid_q <= 1'b1;
        rec_kind_q <= is_end ? REC_END : REC_BEGIN;
        rec_stream_q <= gnt_idx;
        rec_handle_q <= is_end ? end_h : alloc_h;
        rec_has_parent_q <= rec_hp_d;
        rec_parent_q <= rec_hp_d ? par_h : '0;
      end else if (rec_ready) rec_valid_q <= 1'b0;
    end
  end
  assign rec_valid = rec_valid_q;
  assign rec_kind = rec_kind_q;
  assign rec_stream = rec_stream_q;
  assign rec_handle = rec_handle_q;
  assign rec_parent = rec_parent_q;
  assign rec_has_parent = rec_has_parent_q;
  assign pool_empty = empty;
  assign err = err_q;
endmodule

// File: tb/tb_txn_stream_arbiter.sv
// tb_txn_stream_arbiter: directed scenarios plus random traffic against a behavioural pool/arbiter model
module tb_txn_stream_arbiter;
  localparam int N = 5;
  localparam int HW = 4;
  localparam int NH = 16;
  localparam int SW = $clog2(N);
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] rv, re, hp;
  logic [N*HW-1:0] rh, rp;
  logic rr;
  logic [N-1:0] req_ready;
  logic [HW-1:0] grant_handle, rec_handle, rec_parent;
  logic rec_valid, rec_kind, rec_has_parent, pool_empty, err;
  logic [SW-1:0] rec_stream;
  logic [HW:0] live_count;
  int n_chk = 0, n_err = 0;
  int obs_ready, obs_gh;
  bit m_live[NH];
  int m_cnt, m_ptr, m_kind, m_stream, m_handle, m_parent, m_hp;
  bit m_rv, m_err;

  always #5 clk = ~clk;

  txn_stream_arbiter #(.NUM_STREAMS(N), .HANDLE_W(HW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_end(re), .req_handle(rh),
    .req_has_parent(hp), .req_parent(rp), .req_ready(req_ready), .grant_handle(grant_handle),
    .rec_valid(rec_valid), .rec_ready(rr), .rec_kind(rec_kind), .rec_stream(rec_stream),
    .rec_handle(rec_handle), .rec_parent(rec_parent), .rec_has_parent(rec_has_parent),
    .live_count(live_count), .pool_empty(pool_empty), .err(err)
  );

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_live[i]) m_live[i] = 1'b0;
    m_cnt = 0; m_ptr = 0; m_rv = 0; m_err = 0;
    m_kind = 0; m_stream = 0; m_handle = 0; m_parent = 0; m_hp = 0;
  endtask

  task automatic idle();
    rv = '0; re = '0; rh = '0; hp = '0; rp = '0; rr = 1'b1;
  endtask

  task automatic set_req(int s, bit e, int h, bit p, int par);
    rv[s] = 1'b1; re[s] = e; rh[s*HW +: HW] = HW'(h); hp[s] = p; rp[s*HW +: HW] = HW'(par);
  endtask

  // One cycle: compare every output to the model, advance the model, cross the edge
  task automatic step();
    int g, h, s, eh, par;
    bit can, pbad, hpx;
    #2;
    can = !m_rv || rr;
    g = -1;
    if (rst_n && can)
      for (int k = 0; k < N; k++) begin
        s = (m_ptr + k) % N;
        if (g < 0 && rv[s] && (re[s] || m_cnt < NH)) g = s;
      end
    h = -1;
    for (int i = NH - 1; i >= 0; i--) if (!m_live[i]) h = i;
    obs_ready = int'(req_ready);
    obs_gh = int'(grant_handle);
    check("req_ready", obs_ready, g < 0 ? 0 : 1 << g);
    if (g >= 0 && !re[g]) check("grant_handle", obs_gh, h);
    check("live_count", int'(live_count), m_cnt);
    check("pool_empty", int'(pool_empty), int'(m_cnt == NH));
    check("rec_valid", int'(rec_valid), int'(m_rv));
    check("err", int'(err), int'(m_err));
    check("rec_kind", int'(rec_kind), m_kind);
    check("rec_stream", int'(rec_stream), m_stream);
    check("rec_handle", int'(rec_handle), m_handle);
    check("rec_parent", int'(rec_parent), m_parent);
    check("rec_has_parent", int'(rec_has_parent), m_hp);
    m_err = 0;
    if (m_rv && rr) m_rv = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (re[g]) begin
        eh = int'(rh[g*HW +: HW]);
        if (m_live[eh]) begin
          m_live[eh] = 0; m_cnt--; m_rv = 1;
          m_kind = 1; m_stream = g; m_handle = eh; m_parent = 0; m_hp = 0;
        end else m_err = 1;
      end else begin
        par = int'(rp[g*HW +: HW]);
        hpx = hp[g];
`ifdef TXN_ARB_PARENT_CHECK_EN
        pbad = hpx && !m_live[par];
`else
        pbad = 0;
`endif
        m_live[h] = 1; m_cnt++; m_rv = 1;
        m_kind = 0; m_stream = g; m_handle = h;
        m_hp = int'(hpx && !pbad);
        m_parent = m_hp != 0 ? par : 0;
        m_err = pbad;
      end
    end
    if (!rst_n) model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    do_reset();
    // two streams begin together: handles 0 then 1
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    step();
    check("alloc_s0", obs_ready, 1);
    check("alloc_h0", obs_gh, 0);
    rv[0] = 1'b0;
    step();
    check("alloc_s1", obs_ready, 2);
    check("alloc_h1", obs_gh, 1);
    idle();
    step();
    check("alloc_cnt", int'(live_count), 2);
    // fairness with all streams requesting
    do_reset();
    for (int s = 0; s < N; s++) set_req(s, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("fair", obs_ready, 1 << (i % N));
    end
    // pool exhaustion then simultaneous begin/end
    do_reset();
    set_req(0, 0, 0, 0, 0);
    repeat (NH) step();
    check("exh_full", int'(pool_empty), 1);
    idle();
    set_req(2, 0, 0, 0, 0); set_req(3, 1, 5, 0, 0);
    step();
    check("exh_only3", obs_ready, 8);
    rv[3] = 1'b0;
    step();
    check("exh_s2", obs_ready, 4);
    check("exh_h5", obs_gh, 5);
    idle();
    step();
    // back-pressure with a pending record
    do_reset();
    set_req(0, 0, 0, 0, 0);
    step();
    idle();
    rr = 1'b0;
    set_req(1, 0, 0, 0, 0);
    repeat (4) begin
      step();
      check("bp_ready", obs_ready, 0);
      check("bp_valid", int'(rec_valid), 1);
      check("bp_handle", int'(rec_handle), 0);
    end
    idle();
    step();
    // end of a handle that is not live
    do_reset();
    set_req(0, 0, 0, 0, 0);
    step(); step();
    idle();
    step();
    set_req(4, 1, 9, 0, 0);
    step();
    check("bad_grant", obs_ready, 16);
    idle();
    check("bad_err", int'(err), 1);
    check("bad_rec", int'(rec_valid), 0);
    check("bad_cnt", int'(live_count), 2);
    step();
    check("bad_err_once", int'(err), 0);
    // begin naming a parent that is not live
    do_reset();
    set_req(0, 0, 0, 1, 7);
    step();
    idle();
`ifdef TXN_ARB_PARENT_CHECK_EN
    check("par_err", int'(err), 1);
    check("par_hp", int'(rec_has_parent), 0);
`else
    check("par_hp", int'(rec_has_parent), 1);
    check("par_val", int'(rec_parent), 7);
`endif
    step();
    // random traffic with occasional mid-run resets
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst_n = $urandom_range(99) != 0;
      rr = $urandom_range(3) != 0;
      for (int s = 0; s < N; s++)
        set_req(s, $urandom_range(2) == 0, $urandom_range(NH - 1), $urandom_range(1) != 0, $urandom_range(NH - 1));
      rv = N'($urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
